// File: rtl/flow_gen_pkg.sv
// Shared constants, FSM encoding and flow-entry layout for the per-flow frame generator.
package flow_gen_pkg;

    localparam int ETH_HDR_BYTES = 14;
    localparam int MIN_PAYLOAD   = 46;
    localparam int MAX_PAYLOAD   = 1500;

    // Entry word is {d_mac, s_mac, ethertype, payload}
    localparam int ENTRY_W     = 120;
    localparam int PAYLOAD_LSB = 0;
    localparam int ETYPE_LSB   = 8;
    localparam int SMAC_LSB    = 24;
    localparam int DMAC_LSB    = 72;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOOKUP  = 2'd1,
        ST_HEADER  = 2'd2,
        ST_PAYLOAD = 2'd3
    } state_e;

    function automatic logic [10:0] eff_len(input logic [10:0] len);
        if (len < 11'(MIN_PAYLOAD)) return 11'(MIN_PAYLOAD);
        if (len > 11'(MAX_PAYLOAD)) return 11'(MAX_PAYLOAD);
        return len;
    endfunction

    // MAC addresses go out least-significant byte first, EtherType big-endian.
    function automatic logic [7:0] hdr_byte(input logic [ENTRY_W-1:0] e, input logic [3:0] idx);
        logic [47:0] d_mac;
        logic [47:0] s_mac;
        logic [15:0] etype;
        logic [3:0]  s_idx;
        d_mac = e[DMAC_LSB +: 48];
        s_mac = e[SMAC_LSB +: 48];
        etype = e[ETYPE_LSB +: 16];
        s_idx = idx - 4'd6;
        if (idx < 4'd6)   return d_mac[{idx[2:0], 3'b000} +: 8];
        if (idx < 4'd12)  return s_mac[{s_idx[2:0], 3'b000} +: 8];
        if (idx == 4'd12) return etype[15:8];
        return etype[7:0];
    endfunction

endpackage

// File: rtl/flow_frame_gen_if.sv
// Request handshake plus 8-bit AXI-Stream output of the frame generator.
interface flow_frame_gen_if #(
    parameter int FLOW_WIDTH = 8
);
    logic                  req_valid;
    logic                  req_ready;
    logic [FLOW_WIDTH-1:0] req_id;
    logic [10:0]           req_len;
    logic [7:0]            m_axis_tdata;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;
    logic                  m_axis_tlast;

    modport master (
        input  req_valid, req_id, req_len, m_axis_tready,
        output req_ready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
    );

    modport slave (
        output req_valid, req_id, req_len, m_axis_tready,
        input  req_ready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
    );
endinterface

// File: rtl/flow_cfg_ram.sv
// Flow table storage: one write port, one registered read port, read-before-write.
module flow_cfg_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = 8,
    parameter int DW    = 120
) (
    input  logic          clk,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [DW-1:0] rd_data_o
);
    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
        rd_data_o <= mem_q[rd_addr_i];
    end
endmodule

// File: rtl/flow_frame_gen.sv
// Per-flow Ethernet frame generator: flow table, request FSM and AXI-Stream byte mux.
module flow_frame_gen
    import flow_gen_pkg::*;
#(
    parameter  int N_FLOWS    = 256,
    localparam int FLOW_WIDTH = (N_FLOWS <= 1) ? 1 : $clog2(N_FLOWS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_en,
    input  logic [FLOW_WIDTH-1:0] cfg_id,
    input  logic [47:0]           cfg_d_mac,
    input  logic [47:0]           cfg_s_mac,
    input  logic [15:0]           cfg_ethertype,
    input  logic [7:0]            cfg_payload,
    flow_frame_gen_if.master      bus,
    output logic                  req_err,
    output logic [31:0]           frame_cnt
);
    state_e               state_q, state_d;
    logic [ENTRY_W-1:0]   rd_entry;
    logic [ENTRY_W-1:0]   entry_q, entry_d;
    logic [N_FLOWS-1:0]   valid_q;
    logic                 rd_vld_q;
    logic                 ready_en_q;
    logic [10:0]          len_q, len_d;
    logic [10:0]          cnt_q, cnt_d;
    logic [31:0]          frame_cnt_q, frame_cnt_d;
    logic [7:0]           tdata;
    logic                 tvalid, tlast, ready, err;
    logic                 pay_last;

    // Table is read every cycle at the request id so the entry is ready in LOOKUP.
    flow_cfg_ram #(.DEPTH(N_FLOWS), .AW(FLOW_WIDTH), .DW(ENTRY_W)) u_ram (
        .clk       (clk),
        .wr_en_i   (cfg_en),
        .wr_addr_i (cfg_id),
        .wr_data_i ({cfg_d_mac, cfg_s_mac, cfg_ethertype, cfg_payload}),
        .rd_addr_i (bus.req_id),
        .rd_data_o (rd_entry)
    );

    assign pay_last = (cnt_q == len_q - 11'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            valid_q     <= '0;
            rd_vld_q    <= 1'b0;
            ready_en_q  <= 1'b0;
            entry_q     <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ready_en_q  <= 1'b1;
            // Valid bit sampled alongside the RAM read so both see pre-write contents.
            rd_vld_q    <= valid_q[bus.req_id];
            if (cfg_en) valid_q[cfg_id] <= 1'b1;
            entry_q     <= entry_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        entry_d     = entry_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        frame_cnt_d = frame_cnt_q;
        tdata       = 8'h00;
        tvalid      = 1'b0;
        tlast       = 1'b0;
        ready       = 1'b0;
        err         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ready = ready_en_q;
                if (bus.req_valid && ready_en_q) begin
                    len_d   = eff_len(bus.req_len);
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (rd_vld_q) begin
                    entry_d = rd_entry;
                    cnt_d   = '0;
                    state_d = ST_HEADER;
                end else begin
                    err     = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_HEADER: begin
                tvalid = 1'b1;
                tdata  = hdr_byte(entry_q, cnt_q[3:0]);
                if (bus.m_axis_tready) begin
                    if (cnt_q == 11'(ETH_HDR_BYTES - 1)) begin
                        cnt_d   = '0;
                        state_d = ST_PAYLOAD;
                    end else begin
                        cnt_d = cnt_q + 11'd1;
                    end
                end
            end
            ST_PAYLOAD: begin
                tvalid = 1'b1;
                tdata  = entry_q[PAYLOAD_LSB +: 8] + cnt_q[7:0];
                tlast  = pay_last;
                if (bus.m_axis_tready) begin
                    if (pay_last) begin
                        frame_cnt_d = frame_cnt_q + 32'd1;
                        state_d     = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 11'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.req_ready     = ready;
    assign bus.m_axis_tdata  = tdata;
    assign bus.m_axis_tvalid = tvalid;
    assign bus.m_axis_tlast  = tlast;
    assign req_err           = err;
    assign frame_cnt         = frame_cnt_q;
endmodule

// File: tb/tb_flow_frame_gen.sv
// Directed bench for flow_frame_gen: header/payload content, length clamping, stalls, reconfig, reset.
module tb_flow_frame_gen;
    localparam int NF = 256;
    localparam int FW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_en = 1'b0;
    logic [FW-1:0] cfg_id = '0;
    logic [47:0]   cfg_d_mac = '0;
    logic [47:0]   cfg_s_mac = '0;
    logic [15:0]   cfg_ethertype = '0;
    logic [7:0]    cfg_payload = '0;
    logic          req_err;
    logic [31:0]   frame_cnt;

    flow_frame_gen_if #(.FLOW_WIDTH(FW)) bus ();

    flow_frame_gen #(.N_FLOWS(NF)) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_en        (cfg_en),
        .cfg_id        (cfg_id),
        .cfg_d_mac     (cfg_d_mac),
        .cfg_s_mac     (cfg_s_mac),
        .cfg_ethertype (cfg_ethertype),
        .cfg_payload   (cfg_payload),
        .bus           (bus),
        .req_err       (req_err),
        .frame_cnt     (frame_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [47:0] m_d [NF];
    logic [47:0] m_s [NF];
    logic [15:0] m_e [NF];
    logic [7:0]  m_p [NF];
    logic [7:0]  rx [$];
    logic [7:0]  ex [$];
    logic [7:0]  ref_rx [$];
    int first_cyc, stall_err, aborted;
    int exp_frames = 0;

    function automatic int eff_len(input int l);
        if (l < 46)   return 46;
        if (l > 1500) return 1500;
        return l;
    endfunction

    task automatic build_exp(input int id, input int len);
        int n;
        logic [7:0] b;
        n = eff_len(len);
        ex.delete();
        for (int k = 0; k < 14 + n; k++) begin
            if (k < 6)        b = m_d[id][8*k +: 8];
            else if (k < 12)  b = m_s[id][8*(k-6) +: 8];
            else if (k == 12) b = m_e[id][15:8];
            else if (k == 13) b = m_e[id][7:0];
            else              b = m_p[id] + 8'(k - 14);
            ex.push_back(b);
        end
    endtask

    task automatic cmp_frame(input string tag);
        int mism;
        mism = 0;
        for (int i = 0; i < rx.size() && i < ex.size(); i++)
            if (rx[i] !== ex[i]) mism++;
        chk({tag, "_size"}, 32'(rx.size()), 32'(ex.size()));
        chk({tag, "_bytes"}, 32'(mism), 32'd0);
    endtask

    task automatic cfg_flow(input int id, input logic [47:0] d, input logic [47:0] s,
                            input logic [15:0] e, input logic [7:0] p);
        cfg_id = id[FW-1:0]; cfg_d_mac = d; cfg_s_mac = s; cfg_ethertype = e; cfg_payload = p;
        cfg_en = 1'b1;
        m_d[id] = d; m_s[id] = s; m_e[id] = e; m_p[id] = p;
        @(posedge clk); #1;
        cfg_en = 1'b0;
    endtask

    // Leaves time at T+1 (the LOOKUP cycle).
    task automatic accept(input int id, input int len);
        bus.req_id    = id[FW-1:0];
        bus.req_len   = 11'(len);
        bus.req_valid = 1'b1;
        chk("ready_before_accept", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("tvalid_in_lookup", 32'(bus.m_axis_tvalid), 32'd0);
        chk("ready_in_lookup", 32'(bus.req_ready), 32'd0);
    endtask

    task automatic collect(input bit stall, input int recfg_at, input int abort_at);
        logic [7:0] pd;
        logic       pl;
        bit ps, done, recfg_done;
        int cyc;
        ps = 0; done = 0; recfg_done = 0; cyc = 0; pd = '0; pl = 1'b0;
        rx.delete(); first_cyc = -1; stall_err = 0; aborted = 0;
        while (!done && cyc < 4000) begin
            @(posedge clk); #1;
            cyc++;
            cfg_en = 1'b0;
            bus.m_axis_tready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (ps && (bus.m_axis_tvalid !== 1'b1 || bus.m_axis_tdata !== pd || bus.m_axis_tlast !== pl))
                stall_err++;
            if (bus.m_axis_tvalid === 1'b1 && first_cyc < 0) first_cyc = cyc;
            if (abort_at >= 0 && rx.size() == abort_at) begin
                #2 rst = 1'b1;
                #1;
                aborted = 1;
                done = 1;
            end else begin
                if (recfg_at >= 0 && rx.size() == recfg_at && !recfg_done) begin
                    recfg_done = 1;
                    cfg_id = 8'd3; cfg_d_mac = m_d[3]; cfg_s_mac = m_s[3];
                    cfg_ethertype = 16'h0800; cfg_payload = m_p[3];
                    cfg_en = 1'b1;
                    m_e[3] = 16'h0800;
                end
                if (bus.m_axis_tvalid === 1'b1 && bus.m_axis_tready) begin
                    rx.push_back(bus.m_axis_tdata);
                    if (bus.m_axis_tlast === 1'b1) done = 1;
                end
                ps = (bus.m_axis_tvalid === 1'b1) && !bus.m_axis_tready;
                pd = bus.m_axis_tdata;
                pl = bus.m_axis_tlast;
            end
        end
        if (!done) chk("collect_timeout", 32'd0, 32'd1);
        if (!aborted) begin
            @(posedge clk); #1;
            cfg_en = 1'b0;
            bus.m_axis_tready = 1'b1;
            chk("ready_after_last", 32'(bus.req_ready), 32'd1);
            chk("tvalid_after_last", 32'(bus.m_axis_tvalid), 32'd0);
        end
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_id = '0; bus.req_len = '0; bus.m_axis_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
        chk("rst_tlast", 32'(bus.m_axis_tlast), 32'd0);
        chk("rst_tdata", 32'(bus.m_axis_tdata), 32'd0);
        chk("rst_req_err", 32'(req_err), 32'd0);
        chk("rst_frame_cnt", frame_cnt, 32'd0);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_release", 32'(bus.req_ready), 32'd1);

        // Basic frame, flow 3, len 60
        cfg_flow(3, 48'h0A0B0C0D0E0F, 48'h112233445566, 16'h88B5, 8'hF0);
        build_exp(3, 60);
        accept(3, 60);
        collect(0, -1, -1);
        exp_frames++;
        chk("f1_first_tvalid_T2", 32'(first_cyc), 32'd1);
        cmp_frame("f1");
        if (rx.size() == 74) begin
            chk("f1_byte0", 32'(rx[0]), 32'h0F);
            chk("f1_byte6", 32'(rx[6]), 32'h66);
            chk("f1_byte12", 32'(rx[12]), 32'h88);
            chk("f1_byte13", 32'(rx[13]), 32'hB5);
            chk("f1_byte14", 32'(rx[14]), 32'hF0);
            chk("f1_byte30_wrap", 32'(rx[30]), 32'h00);
            chk("f1_byte73_last", 32'(rx[73]), 32'h2B);
        end
        chk("f1_frame_cnt", frame_cnt, 32'(exp_frames));

        // Unconfigured flow
        accept(7, 60);
        chk("err_pulse_T1", 32'(req_err), 32'd1);
        @(posedge clk); #1;
        chk("err_low_T2", 32'(req_err), 32'd0);
        chk("err_ready_T2", 32'(bus.req_ready), 32'd1);
        chk("err_no_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
        chk("err_frame_cnt", frame_cnt, 32'(exp_frames));

        // Length clamping
        cfg_flow(5, 48'h010203040506, 48'hA1A2A3A4A5A6, 16'h0806, 8'h00);
        build_exp(5, 10);
        accept(5, 10);
        collect(0, -1, -1);
        exp_frames++;
        cmp_frame("len10");
        if (rx.size() == 60) chk("len10_last_byte", 32'(rx[59]), 32'h2D);
        chk("len10_byte0", 32'(rx.size() > 0 ? rx[0] : 8'hXX), 32'h06);

        build_exp(5, 2000);
        accept(5, 2000);
        collect(0, -1, -1);
        exp_frames++;
        cmp_frame("len2000");
        if (rx.size() == 1514) chk("len2000_last_byte", 32'(rx[1513]), 32'hDB);

        build_exp(5, 47);
        accept(5, 47);
        collect(0, -1, -1);
        exp_frames++;
        cmp_frame("len47");
        chk("clamp_frame_cnt", frame_cnt, 32'(exp_frames));

        // Stall run must reproduce the no-stall byte sequence
        build_exp(3, 100);
        accept(3, 100);
        collect(0, -1, -1);
        exp_frames++;
        cmp_frame("len100_nostall");
        ref_rx = rx;
        accept(3, 100);
        collect(1, -1, -1);
        exp_frames++;
        cmp_frame("len100_stall");
        chk("stall_stable", 32'(stall_err), 32'd0);
        chk("stall_vs_nostall_size", 32'(rx.size()), 32'(ref_rx.size()));
        begin
            int d;
            d = 0;
            for (int i = 0; i < rx.size() && i < ref_rx.size(); i++)
                if (rx[i] !== ref_rx[i]) d++;
            chk("stall_vs_nostall_bytes", 32'(d), 32'd0);
        end

        // Reconfig during payload: snapshot protects frame in flight
        build_exp(3, 60);
        accept(3, 60);
        collect(0, 20, -1);
        exp_frames++;
        cmp_frame("recfg_first");
        if (rx.size() > 13) begin
            chk("recfg_first_et_hi", 32'(rx[12]), 32'h88);
            chk("recfg_first_et_lo", 32'(rx[13]), 32'hB5);
        end
        build_exp(3, 60);
        accept(3, 60);
        collect(0, -1, -1);
        exp_frames++;
        cmp_frame("recfg_second");
        if (rx.size() > 13) begin
            chk("recfg_second_et_hi", 32'(rx[12]), 32'h08);
            chk("recfg_second_et_lo", 32'(rx[13]), 32'h00);
        end
        chk("recfg_frame_cnt", frame_cnt, 32'(exp_frames));

        // Reset at payload byte 20
        accept(3, 60);
        collect(0, -1, 34);
        chk("abort_reached", 32'(aborted), 32'd1);
        chk("abort_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
        chk("abort_tlast", 32'(bus.m_axis_tlast), 32'd0);
        chk("abort_tdata", 32'(bus.m_axis_tdata), 32'd0);
        chk("abort_ready", 32'(bus.req_ready), 32'd0);
        chk("abort_frame_cnt", frame_cnt, 32'd0);
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk); #1;
        accept(3, 60);
        chk("post_rst_err", 32'(req_err), 32'd1);
        @(posedge clk); #1;
        chk("post_rst_no_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
        chk("post_rst_frame_cnt", frame_cnt, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
